// File: rtl/movi_exec_if.sv
// movi_exec_if: instruction/start/flush request side and decoded datapath controls of the move-immediate FSM.
interface movi_exec_if #(
    parameter int INSTR_W  = 16,
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 6
);
    logic [INSTR_W-1:0]  instr;
    logic                start;
    logic                flush;
    logic                busy;
    logic                pc_inc;
    logic                imm_oe;
    logic [DATA_W-1:0]   imm_bus;
    logic [NUM_REGS-1:0] reg_we;
    logic                done;
    logic                err;

    modport master (
        output instr, start, flush,
        input  busy, pc_inc, imm_oe, imm_bus, reg_we, done, err
    );

    modport slave (
        input  instr, start, flush,
        output busy, pc_inc, imm_oe, imm_bus, reg_we, done, err
    );
endinterface

// File: rtl/movi_exec_fsm.sv
// movi_exec_fsm: Moore FSM executing move-immediate instructions (PC increment, immediate drive, one-hot register write).
module movi_exec_fsm #(
    parameter int                INSTR_W  = 16,
    parameter int                OPC_W    = 4,
    parameter int                DST_W    = 6,
    parameter int                IMM_W    = 6,
    parameter int                DATA_W   = 16,
    parameter int                NUM_REGS = 6,
    parameter logic [OPC_W-1:0]  OPC_LO   = 4'b0111,
    parameter logic [OPC_W-1:0]  OPC_HI   = 4'b1000,
    parameter bit                SIGN_EXT = 1'b0
) (
    input logic        clk,
    input logic        rst,
    movi_exec_if.slave bus
);
    typedef enum logic [2:0] {IDLE, FETCH, DRIVE, WRITE, DONE, HOLD} state_t;

    state_t             state, state_nxt;
    logic [INSTR_W-1:0] instr_q;
    logic [OPC_W-1:0]   opc_in, opc;
    logic [DST_W-1:0]   dst;
    logic [IMM_W-1:0]   imm;
    logic [DATA_W-1:0]  imm_fmt;
    logic               accept, legal;

    assign opc_in = bus.instr[INSTR_W-1 -: OPC_W];
    assign opc    = instr_q[INSTR_W-1 -: OPC_W];
    assign dst    = instr_q[INSTR_W-OPC_W-1 -: DST_W];
    assign imm    = instr_q[IMM_W-1:0];
    assign accept = bus.start && (opc_in == OPC_LO || opc_in == OPC_HI);
    assign legal  = 32'(dst) < NUM_REGS;

    // High load shifts by DATA_W-IMM_W, which degenerates to the raw imm when the widths match.
    assign imm_fmt = (opc == OPC_HI) ? (DATA_W'(imm) << (DATA_W - IMM_W))
                   : SIGN_EXT ? DATA_W'($signed(imm)) : DATA_W'(imm);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            instr_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && accept)
                instr_q <= bus.instr;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:                state_nxt = accept ? FETCH : IDLE;
            FETCH:               state_nxt = bus.flush ? (bus.start ? HOLD : IDLE) : DRIVE;
            DRIVE:               state_nxt = bus.flush ? (bus.start ? HOLD : IDLE) : WRITE;
            WRITE:               state_nxt = bus.flush ? (bus.start ? HOLD : IDLE) : DONE;
            DONE, HOLD:          state_nxt = bus.start ? HOLD : IDLE;
            default:             state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy    = state != IDLE;
        bus.pc_inc  = state == FETCH;
        bus.imm_oe  = state == DRIVE || state == WRITE;
        bus.imm_bus = bus.imm_oe ? imm_fmt : '0;
        bus.reg_we  = (state == WRITE && legal) ? (NUM_REGS'(1) << dst) : '0;
        bus.done    = state == DONE;
        bus.err     = state == DONE && !legal;
    end
endmodule

// File: tb/tb_movi_exec_fsm.sv
// tb_movi_exec_fsm: directed checks of the move-immediate FSM, zero-extend (d0) and sign-extend (d1) instances side by side.
module tb_movi_exec_fsm;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] instr = '0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    int          total = 0;
    int          passed = 0;

    always #5 clk = ~clk;

    movi_exec_if #(.INSTR_W(16), .DATA_W(16), .NUM_REGS(6)) b0 ();
    movi_exec_if #(.INSTR_W(16), .DATA_W(16), .NUM_REGS(6)) b1 ();

    assign b0.instr = instr;
    assign b0.start = start;
    assign b0.flush = flush;
    assign b1.instr = instr;
    assign b1.start = start;
    assign b1.flush = flush;

    movi_exec_fsm #(.SIGN_EXT(1'b0)) d0 (.clk(clk), .rst(rst), .bus(b0.slave));
    movi_exec_fsm #(.SIGN_EXT(1'b1)) d1 (.clk(clk), .rst(rst), .bus(b1.slave));

    // Packed view {busy,pc_inc,imm_oe,done,err, reg_we[5:0], imm_bus[15:0]}
    function automatic logic [26:0] o0();
        return {b0.busy, b0.pc_inc, b0.imm_oe, b0.done, b0.err, b0.reg_we, b0.imm_bus};
    endfunction

    function automatic logic [26:0] o1();
        return {b1.busy, b1.pc_inc, b1.imm_oe, b1.done, b1.err, b1.reg_we, b1.imm_bus};
    endfunction

    task automatic test_reset();
        @(negedge clk);
        total++;
        if (o0() !== 27'd0) $display("FAIL reset_d0 got=%h want=%h", o0(), 27'd0); else passed++;
        total++;
        if (o1() !== 27'd0) $display("FAIL reset_d1 got=%h want=%h", o1(), 27'd0); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_low_load();
        @(negedge clk); instr = 16'h70C5; start = 1'b1;
        @(negedge clk); start = 1'b0;
        total++;
        if (o0() !== {5'b11000, 6'b0, 16'h0}) $display("FAIL lo_fetch got=%h want=%h", o0(), {5'b11000, 6'b0, 16'h0}); else passed++;
        @(negedge clk);
        total++;
        if (o0() !== {5'b10100, 6'b0, 16'h0005}) $display("FAIL lo_drive got=%h want=%h", o0(), {5'b10100, 6'b0, 16'h0005}); else passed++;
        @(negedge clk);
        total++;
        if (o0() !== {5'b10100, 6'b001000, 16'h0005}) $display("FAIL lo_write got=%h want=%h", o0(), {5'b10100, 6'b001000, 16'h0005}); else passed++;
        @(negedge clk);
        total++;
        if (o0() !== {5'b10010, 6'b0, 16'h0}) $display("FAIL lo_done got=%h want=%h", o0(), {5'b10010, 6'b0, 16'h0}); else passed++;
        @(negedge clk);
        total++;
        if (o0() !== 27'd0) $display("FAIL lo_idle got=%h want=%h", o0(), 27'd0); else passed++;
    endtask

    task automatic test_sign_ext();
        @(negedge clk); instr = 16'h7060; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        total++;
        if (o1() !== {5'b10100, 6'b0, 16'hFFE0}) $display("FAIL sx_drive got=%h want=%h", o1(), {5'b10100, 6'b0, 16'hFFE0}); else passed++;
        total++;
        if (o0() !== {5'b10100, 6'b0, 16'h0020}) $display("FAIL zx_drive got=%h want=%h", o0(), {5'b10100, 6'b0, 16'h0020}); else passed++;
        @(negedge clk);
        total++;
        if (o1() !== {5'b10100, 6'b000010, 16'hFFE0}) $display("FAIL sx_write got=%h want=%h", o1(), {5'b10100, 6'b000010, 16'hFFE0}); else passed++;
        total++;
        if (o0() !== {5'b10100, 6'b000010, 16'h0020}) $display("FAIL zx_write got=%h want=%h", o0(), {5'b10100, 6'b000010, 16'h0020}); else passed++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_high_load();
        @(negedge clk); instr = 16'h803F; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        total++;
        if (o0() !== {5'b10100, 6'b0, 16'hFC00}) $display("FAIL hi_drive got=%h want=%h", o0(), {5'b10100, 6'b0, 16'hFC00}); else passed++;
        @(negedge clk);
        total++;
        if (o1() !== {5'b10100, 6'b000001, 16'hFC00}) $display("FAIL hi_write_sx got=%h want=%h", o1(), {5'b10100, 6'b000001, 16'hFC00}); else passed++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_illegal_dst();
        @(negedge clk); instr = 16'h71C1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (o0() !== {5'b10100, 6'b0, 16'h0001}) $display("FAIL bad_dst_write got=%h want=%h", o0(), {5'b10100, 6'b0, 16'h0001}); else passed++;
        @(negedge clk);
        total++;
        if (o0() !== {5'b10011, 6'b0, 16'h0}) $display("FAIL bad_dst_done got=%h want=%h", o0(), {5'b10011, 6'b0, 16'h0}); else passed++;
        @(negedge clk);
    endtask

    task automatic test_held_start();
        int pcs = 0;
        int dones = 0;
        @(negedge clk); instr = 16'h70C5; start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            pcs += int'(b0.pc_inc);
            dones += int'(b0.done);
        end
        total++;
        if (pcs !== 1) $display("FAIL held_pc_inc got=%0d want=1", pcs); else passed++;
        total++;
        if (dones !== 1) $display("FAIL held_done got=%0d want=1", dones); else passed++;
        total++;
        if (o0() !== {5'b10000, 6'b0, 16'h0}) $display("FAIL held_hold got=%h want=%h", o0(), {5'b10000, 6'b0, 16'h0}); else passed++;
        start = 1'b0;
        @(negedge clk);
        total++;
        if (o0() !== 27'd0) $display("FAIL held_release got=%h want=%h", o0(), 27'd0); else passed++;
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        total++;
        if (o0() !== {5'b11000, 6'b0, 16'h0}) $display("FAIL retrigger got=%h want=%h", o0(), {5'b11000, 6'b0, 16'h0}); else passed++;
        repeat (4) @(negedge clk);
        total++;
        if (o0() !== 27'd0) $display("FAIL retrigger_idle got=%h want=%h", o0(), 27'd0); else passed++;
    endtask

    task automatic test_flush();
        @(negedge clk); instr = 16'h70C5; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); flush = 1'b1;
        total++;
        if (o0() !== {5'b10100, 6'b0, 16'h0005}) $display("FAIL flush_drive got=%h want=%h", o0(), {5'b10100, 6'b0, 16'h0005}); else passed++;
        @(negedge clk); flush = 1'b0;
        total++;
        if (o0() !== 27'd0) $display("FAIL flush_idle got=%h want=%h", o0(), 27'd0); else passed++;
        @(negedge clk);
        total++;
        if (o0() !== 27'd0) $display("FAIL flush_no_done got=%h want=%h", o0(), 27'd0); else passed++;
    endtask

    task automatic test_reset_mid();
        @(negedge clk); instr = 16'h70C5; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (o0() !== {5'b10100, 6'b001000, 16'h0005}) $display("FAIL rst_pre_write got=%h want=%h", o0(), {5'b10100, 6'b001000, 16'h0005}); else passed++;
        #1 rst = 1'b1;
        #1;
        total++;
        if (o0() !== 27'd0) $display("FAIL rst_mid got=%h want=%h", o0(), 27'd0); else passed++;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        total++;
        if (o0() !== 27'd0) $display("FAIL rst_after got=%h want=%h", o0(), 27'd0); else passed++;
    endtask

    task automatic test_bad_opcode();
        @(negedge clk); instr = 16'h30C5; start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (o0() !== 27'd0) $display("FAIL bad_opc_%0d got=%h want=%h", i, o0(), 27'd0); else passed++;
        end
        start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_low_load();
        test_sign_ext();
        test_high_load();
        test_illegal_dst();
        test_held_start();
        test_flush();
        test_reset_mid();
        test_bad_opcode();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/movi_exec_fsm.md
Name: movi_exec_fsm

Overview:
- Parametrised execution FSM for move-immediate instructions in the microcontroller datapath.
- Latches an instruction on a start handshake and requests a PC increment.
- Drives a zero- or sign-extended immediate onto the shared data bus, optionally shifted into the upper bits for the high-load opcode.
- Pulses a one-hot register write enable, then signals done. An illegal destination or a flush ends the sequence without any write.

Parameters:
- INSTR_W, 16, instruction width; must equal OPC_W+DST_W+IMM_W.
- OPC_W, 4, opcode field width at instr[INSTR_W-1 -: OPC_W].
- DST_W, 6, destination field width, immediately below the opcode.
- IMM_W, 6, immediate field width at instr[IMM_W-1:0].
- DATA_W, 16, bus width; must be >= IMM_W.
- NUM_REGS, 6, number of writable registers (one-hot enables); index 0..NUM_REGS-1.
- OPC_LO, 4'b0111, opcode for low load: imm to bus bits [IMM_W-1:0], extended upward.
- OPC_HI, 4'b1000, opcode for high load: imm to bus bits [DATA_W-1 -: IMM_W], lower bits zero.
- SIGN_EXT, 0, 1 = sign-extend the low-load immediate; 0 = zero-extend.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, asynchronous, active-high reset.
- instr, input, INSTR_W, current instruction word; sampled only on acceptance.
- start, input, 1, level request to execute instr.
- flush, input, 1, synchronous abort of the sequence in progress.
- busy, output, 1, high in every state except IDLE.
- pc_inc, output, 1, one-cycle PC increment request.
- imm_oe, output, 1, immediate bus output enable.
- imm_bus, output, DATA_W, formatted immediate; zero whenever imm_oe=0.
- reg_we, output, NUM_REGS, one-hot register load enable.
- done, output, 1, one-cycle completion pulse.
- err, output, 1, one-cycle pulse, coincident with done, when the destination index is >= NUM_REGS.

Behaviour:
- Reset (rst high, asynchronous): state=IDLE, latched instruction=0. All outputs are 0 and imm_bus=0 while rst is high.
- States: IDLE, FETCH, DRIVE, WRITE, DONE, HOLD. All outputs are decoded from the state and the latched instruction only (Moore); there is no combinational path from the inputs to the outputs.
- IDLE:
  - If start=1 and the instr opcode equals OPC_LO or OPC_HI, latch instr and go to FETCH.
  - If start=1 with any other opcode, stay in IDLE; no output activity.
- FETCH: pc_inc=1 for exactly one cycle. Next state DRIVE.
- DRIVE: imm_oe=1, imm_bus valid, reg_we=0 (bus settle cycle). Next state WRITE.
- WRITE: imm_oe=1, imm_bus held. reg_we[dst]=1 if dst<NUM_REGS, else all reg_we bits 0. Next state DONE.
- DONE: done=1; err=1 if dst>=NUM_REGS. Next state HOLD if start=1, else IDLE.
- HOLD: all outputs 0 except busy. Go to IDLE when start=0. This prevents a held start from retriggering the sequence.
- Latency: acceptance edge to the done cycle is 4 cycles. A back-to-back instruction is accepted no earlier than the cycle after start is dropped.
- Immediate formatting:
  - OPC_LO: bits [IMM_W-1:0]=imm. Upper DATA_W-IMM_W bits are imm[IMM_W-1] if SIGN_EXT=1, else 0.
  - OPC_HI: imm placed at the top IMM_W bits, lower bits 0. SIGN_EXT has no effect.
  - DATA_W==IMM_W: both opcodes produce the imm unchanged.
- flush=1 in FETCH, DRIVE, WRITE or DONE: next state is IDLE (or HOLD if start=1). The current cycle's outputs still follow the present state, so a write in progress in the WRITE cycle completes. No done or err is issued after a flushed DRIVE or FETCH. flush in IDLE or HOLD has no effect.
- reset asserted mid-sequence: immediate return to IDLE, outputs 0. The latched instruction is cleared.
- At most one reg_we bit is ever high. reg_we is never high outside WRITE.
- pc_inc is asserted exactly once per accepted instruction, including flushed or illegal ones that reach FETCH.

Test Plan:
- Default params, instr=16'h70C5 (opc 7, dst 3, imm 5), start pulse of 1 cycle -> pc_inc at cycle 1; imm_bus=16'h0005 in cycles 2-3; reg_we=6'b001000 in cycle 3; done in cycle 4; busy low at cycle 5.
- SIGN_EXT=1, instr=16'h7060 (dst 1, imm 6'b100000) -> imm_bus=16'hFFE0, reg_we=6'b000010; same instr with SIGN_EXT=0 -> imm_bus=16'h0020.
- OPC_HI, instr=16'h803F (dst 0, imm 6'h3F) -> imm_bus=16'hFC00, reg_we=6'b000001.
- instr=16'h71C1 (dst 7 >= NUM_REGS) -> reg_we=0 throughout; done=1 and err=1 in the same cycle.
- start held high for 10 cycles with a valid instr -> exactly one pc_inc and one done; HOLD until start falls, then IDLE; a new start pulse re-executes.
- flush in DRIVE -> no reg_we, no done, IDLE next. rst asserted in WRITE -> all outputs 0 immediately. instr=16'h30C5 with start -> no activity, busy stays 0.
